// File: rtl/adder_colour_stream_fmt.sv
// Multi-channel ANSI SGR colour wrapper: ESC[<code>m + payload + ESC[0m onto one byte stream.
// Define ADDER_COLOUR_BOLD_EN to emit a bold prefix ESC[1;<code>m instead.
module adder_colour_stream_fmt #(
   parameter int NUM_CH = 2,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     in_valid,
   output logic [NUM_CH-1:0]     in_ready,
   input  logic [NUM_CH*8-1:0]   in_data,
   input  logic [NUM_CH-1:0]     in_last,
   input  logic [NUM_CH*3-1:0]   in_colour,
   input  logic [NUM_CH-1:0]     in_bg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_data,
   output logic                  out_last,
   output logic [CH_W-1:0]       out_ch,
   output logic                  busy,
   output logic                  err_colour
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GRANT   = 3'd1;
   localparam logic [2:0] S_PREFIX  = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_SUFFIX  = 3'd4;

`ifdef ADDER_COLOUR_BOLD_EN
   localparam logic [2:0] DIG_BASE = 3'd4;
`else
   localparam logic [2:0] DIG_BASE = 3'd2;
`endif

   logic [2:0]       state;
   logic [CH_W-1:0]  rr;
   logic [CH_W-1:0]  g;
   logic [CH_W-1:0]  pick;
   logic             pick_ok;
   logic [2:0]       idx;
   logic [2:0]       off;
   logic [2:0]       ndig;
   logic [3:0][3:0]  dig_q;
   logic [3:0][3:0]  dig_n;
   logic             ndig3_q;
   logic             ndig3_n;
   logic             load_en;
   logic [2:0]       col_g;
   logic [2:0]       col_eff;
   logic             bg_g;
   logic [7:0]       pre_byte;
   logic [7:0]       suf_byte;
   logic             pre_end;

   assign load_en = !out_valid || out_ready;
   assign col_g   = in_colour[int'(g)*3 +: 3];
   assign bg_g    = in_bg[g];
   assign busy    = (state != S_IDLE);
   assign err_colour = (state == S_GRANT) && (col_g > 3'd4);

   // Round-robin: scan downward so the requester nearest rr is assigned last and wins.
   always_comb begin
      int j;
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         j = int'(rr) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (in_valid[j]) begin
            pick    = CH_W'(j);
            pick_ok = 1'b1;
         end
      end
   end

   // Decimal digits of the SGR code, most significant first in dig_n[0].
   always_comb begin
      col_eff = (col_g > 3'd4) ? 3'd0 : col_g;
      dig_n   = '0;
      ndig3_n = 1'b0;
      case (col_eff)
         3'd1: begin
            if (bg_g) begin
               dig_n   = {4'd0, 4'd4, 4'd0, 4'd1};
               ndig3_n = 1'b1;
            end else begin
               dig_n = {4'd0, 4'd0, 4'd4, 4'd9};
            end
         end
         3'd2:    dig_n = {4'd0, 4'd0, 4'd3, bg_g ? 4'd4 : 4'd3};
         3'd3:    dig_n = {4'd0, 4'd0, 4'd1, bg_g ? 4'd4 : 4'd3};
         3'd4:    dig_n = {4'd0, 4'd0, 4'd2, bg_g ? 4'd4 : 4'd3};
         default: dig_n = {4'd0, 4'd0, 4'd7, bg_g ? 4'd4 : 4'd3};
      endcase
   end

   assign ndig    = ndig3_q ? 3'd3 : 3'd2;
   assign off     = idx - DIG_BASE;
   assign pre_end = (idx == DIG_BASE + ndig);

   always_comb begin
      pre_byte = 8'h6D;
      if (idx == 3'd0)      pre_byte = 8'h1B;
      else if (idx == 3'd1) pre_byte = 8'h5B;
`ifdef ADDER_COLOUR_BOLD_EN
      else if (idx == 3'd2) pre_byte = 8'h31;
      else if (idx == 3'd3) pre_byte = 8'h3B;
`endif
      else if (off < ndig)  pre_byte = {4'h3, dig_q[off[1:0]]};
   end

   always_comb begin
      case (idx[1:0])
         2'd0:    suf_byte = 8'h1B;
         2'd1:    suf_byte = 8'h5B;
         2'd2:    suf_byte = 8'h30;
         default: suf_byte = 8'h6D;
      endcase
   end

   always_comb begin
      in_ready = '0;
      if (state == S_PAYLOAD) in_ready[g] = load_en;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr        <= '0;
         g         <= '0;
         idx       <= '0;
         dig_q     <= '0;
         ndig3_q   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else begin
         // A consumed or empty slot drains unless this state refills it below.
         if (load_en) out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  g     <= pick;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               dig_q   <= dig_n;
               ndig3_q <= ndig3_n;
               idx     <= '0;
               state   <= S_PREFIX;
            end
            S_PREFIX: begin
               if (load_en) begin
                  out_valid <= 1'b1;
                  out_data  <= pre_byte;
                  out_last  <= 1'b0;
                  out_ch    <= g;
                  if (pre_end) begin
                     idx   <= '0;
                     state <= S_PAYLOAD;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            S_PAYLOAD: begin
               if (load_en && in_valid[g]) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data[int'(g)*8 +: 8];
                  out_last  <= 1'b0;
                  out_ch    <= g;
                  if (in_last[g]) begin
                     idx   <= '0;
                     state <= S_SUFFIX;
                  end
               end
            end
            S_SUFFIX: begin
               if (load_en) begin
                  out_valid <= 1'b1;
                  out_data  <= suf_byte;
                  out_last  <= (idx[1:0] == 2'd3);
                  out_ch    <= g;
                  if (idx[1:0] == 2'd3) begin
                     idx   <= '0;
                     rr    <= (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/adder_colour_stream_fmt.md
Name: adder_colour_stream_fmt

Overview:
Synthesisable multi-channel ANSI colour formatter for the adder bench's hardware log path. It is the RTL counterpart of the bench's colourise function, generalised to NUM_CH input byte streams, foreground/background mode and round-robin arbitration. Each input message is wrapped as: SGR prefix ESC '[' <code> 'm', then the payload bytes, then the reset suffix ESC '[' '0' 'm'. Output is a single byte stream feeding the UART/trace sink.

Parameters:
NUM_CH, 2, number of input message channels (1..8)
CH_W, $clog2(NUM_CH) (min 1), width of out_ch

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  NUM_CH  per-channel payload byte valid
in_ready  out  NUM_CH  per-channel byte accepted
in_data  in  NUM_CH*8  per-channel payload byte, channel i at [8i+7:8i]
in_last  in  NUM_CH  final payload byte of message
in_colour  in  NUM_CH*3  colour index: 0 WHITE, 1 BLUE, 2 YELLOW, 3 RED, 4 GREEN
in_bg  in  NUM_CH  1 = background code (fg code + 10)
out_valid  out  1  output byte valid
out_ready  in  1  sink accepts byte
out_data  out  8  formatted byte
out_last  out  1  final byte of formatted message (suffix 'm')
out_ch  out  CH_W  source channel of current byte
busy  out  1  message in flight (state != IDLE)
err_colour  out  1  one-cycle pulse when index 5..7 is sampled

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, rr pointer 0, out_valid/out_last/busy/err_colour = 0, out_data/out_ch = 0, in_ready = 0. Reset mid-message aborts it; no suffix is emitted.
- Fg codes: WHITE 37, BLUE 94, YELLOW 33, RED 31, GREEN 32. Bg codes add 10: 47, 104, 43, 41, 42.
- Index 5..7 is treated as WHITE. err_colour pulses for 1 cycle at sampling.
- Output register: one entry. It loads when !out_valid || out_ready. out_data, out_last and out_ch must stay stable while out_valid && !out_ready.
- FSM states: IDLE -> GRANT -> PREFIX -> PAYLOAD -> SUFFIX -> IDLE.
- IDLE: if any in_valid, pick the first requester at or after the rr pointer. Next cycle enter GRANT. If no in_valid, stay in IDLE.
- GRANT: sample the granted channel's in_colour/in_bg from its first (unconsumed) beat. Compute the code and digit count (3 digits only for 104). Assert err_colour if needed. Go to PREFIX.
- PREFIX: emit 0x1B, 0x5B, the ASCII digits (most significant first), then 0x6D, one byte per output-register load. in_ready stays 0. After 'm' is loaded, go to PAYLOAD.
- PAYLOAD: in_ready[g] = !out_valid || out_ready, combinational; other channels get 0. Each accepted byte passes through with out_last = 0. Throughput is 1 byte/cycle with no bubbles. When a byte with in_last is accepted, go to SUFFIX. in_valid low causes a bubble and the FSM waits.
- SUFFIX: emit 0x1B, 0x5B, 0x30, 0x6D. out_last = 1 on 0x6D only. Once 0x6D is loaded, set rr pointer = (g+1) mod NUM_CH and return to IDLE.
- Channel lock: the granted channel holds the output until its suffix completes. No interleaving between messages.
- Latency: first prefix byte appears on out_valid 3 cycles after in_valid rises in IDLE (IDLE -> GRANT -> PREFIX load -> visible).
- Per message: fg/bg overhead is prefix 5 bytes (6 for code 104) plus suffix 4 bytes.
- Simultaneous requests are resolved by round-robin only. A channel deasserting in_valid before its grant is simply skipped.
- in_colour/in_bg changes after GRANT are ignored for the rest of the message.
- busy = 1 from GRANT through the cycle the suffix 'm' is loaded.

Optional Feature:
ADDER_COLOUR_BOLD_EN
- Defined: prefix becomes ESC '[' '1' ';' <code> 'm', i.e. 0x31 0x3B is inserted after 0x5B (+2 bytes). Suffix is unchanged.
- Undefined: plain prefix as above, and no extra logic is generated.

Test Plan:
- Ch0 RED fg, payload 0x4F,0x4B, out_ready=1 -> output 1B 5B 33 31 6D 4F 4B 1B 5B 30 6D; out_last only on final 6D; out_ch=0 on all bytes.
- Ch1 BLUE bg, payload 0x41 -> output 1B 5B 31 30 34 6D 41 1B 5B 30 6D (3-digit code path).
- Ch0 and ch1 both valid after reset, 1-byte messages -> ch0 message completes fully, then ch1. A new ch0 message queued during ch1 is served after ch1 (rr pointer = 0).
- out_ready held 0 for 3 cycles while 0x5B is presented -> out_data stays 0x5B and in_ready stays 0; resumes with no lost or duplicated bytes.
- Ch0 in_colour=6, fg -> err_colour pulses once in GRANT and prefix code is 37 (33 37).
- rst_n=0 for 1 cycle mid-payload -> next cycle out_valid=0, busy=0, in_ready=0. A fresh ch1 message is served first-come (rr pointer 0, ch0 idle) with a full prefix.
